// File: rtl/gol_pkg.sv
// Shared constants and types for the Game of Life display path: board geometry,
// screen size, cell colours and the plotter state encoding.
package gol_pkg;

    localparam int COLS       = 40;
    localparam int ROWS       = 30;
    localparam int CELL_SIZE  = 4;
    localparam int CELL_SHIFT = $clog2(CELL_SIZE);
    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int ROW_W = 5;
    localparam int COL_W = 6;

    localparam logic [2:0] LIVE_COLOUR = 3'b010;
    localparam logic [2:0] DEAD_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CELL,
        S_CLEAR,
        S_DONE
    } plot_state_t;

endpackage

// File: rtl/gol_xy_scanner.sv
// Raster 2-D counter: sx runs 0..x_limit fastest, sy 0..y_limit; last marks the
// final coordinate. Shared by the per-cell scan and the full-screen clear sweep.
module gol_xy_scanner
    import gol_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           enable,
    input  logic [X_W-1:0] x_limit,
    input  logic [Y_W-1:0] y_limit,
    output logic [X_W-1:0] sx,
    output logic [Y_W-1:0] sy,
    output logic           last
);

    logic x_end;
    logic y_end;

    assign x_end = (sx == x_limit);
    assign y_end = (sy == y_limit);
    assign last  = x_end && y_end;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sx <= '0;
            sy <= '0;
        end else if (enable) begin
            if (x_end) begin
                sx <= '0;
                sy <= y_end ? '0 : sy + 1'b1;
            end else begin
                sx <= sx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gol_cell_plotter.sv
// Expands one cell-draw request into CELL_SIZE x CELL_SIZE registered pixel
// writes for the VGA adapter, or sweeps the whole screen to DEAD_COLOUR.
//
//   state   | meaning
//   S_IDLE  | ready for a request; clear_req has priority
//   S_CELL  | emitting the pixels of the latched cell
//   S_CLEAR | emitting the full-screen sweep
//   S_DONE  | one-cycle completion pulse, no writes
module gol_cell_plotter
    import gol_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    input  logic             req_alive,
    input  logic             clear_req,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [2:0]       colour,
    output logic             writeEn,
    output logic             busy,
    output logic             done
);

    plot_state_t state;
    plot_state_t next_state;

    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic             alive_q;
    logic             pix_last_q;

    logic             in_range;
    logic             start_cell;
    logic             start_clear;
    logic             clear_mode;
    logic             emit;
    logic             scan_clear;
    logic             scan_last;
    logic [X_W-1:0]   sx;
    logic [Y_W-1:0]   sy;
    logic [X_W-1:0]   x_limit;
    logic [Y_W-1:0]   y_limit;
    logic [ROW_W-1:0] row_sel;
    logic [COL_W-1:0] col_sel;
    logic             alive_sel;
    logic [X_W-1:0]   base_x;
    logic [Y_W-1:0]   base_y;
    logic [X_W-1:0]   px_x;
    logic [Y_W-1:0]   px_y;
    logic [2:0]       px_colour;

    assign req_ready   = (state == S_IDLE) && !clear_req;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign in_range    = (req_row < ROW_W'(ROWS)) && (req_col < COL_W'(COLS));
    assign start_clear = (state == S_IDLE) && clear_req;
    assign start_cell  = req_ready && req_valid && in_range;
    assign clear_mode  = start_clear || (state == S_CLEAR);

    // The first pixel is registered on the accepting edge, so the scanner runs
    // one coordinate ahead of the outputs; pix_last_q flags the final write.
    assign emit = start_cell || start_clear ||
                  (((state == S_CELL) || (state == S_CLEAR)) && !pix_last_q);
    assign scan_clear = ((state == S_IDLE) && !emit) || (state == S_DONE);

    assign x_limit = clear_mode ? X_W'(SCREEN_W - 1) : X_W'(CELL_SIZE - 1);
    assign y_limit = clear_mode ? Y_W'(SCREEN_H - 1) : Y_W'(CELL_SIZE - 1);

    // While idle the request is still on the inputs; afterwards use the latch.
    assign row_sel   = (state == S_IDLE) ? req_row   : row_q;
    assign col_sel   = (state == S_IDLE) ? req_col   : col_q;
    assign alive_sel = (state == S_IDLE) ? req_alive : alive_q;

    assign base_x    = X_W'(col_sel) << CELL_SHIFT;
    assign base_y    = Y_W'(row_sel) << CELL_SHIFT;
    assign px_x      = clear_mode ? sx : base_x + sx;
    assign px_y      = clear_mode ? sy : base_y + sy;
    assign px_colour = (!clear_mode && alive_sel) ? LIVE_COLOUR : DEAD_COLOUR;

    gol_xy_scanner u_scanner (
        .clk     (clk),
        .reset   (reset),
        .clear   (scan_clear),
        .enable  (emit),
        .x_limit (x_limit),
        .y_limit (y_limit),
        .sx      (sx),
        .sy      (sy),
        .last    (scan_last)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (clear_req)
                    next_state = S_CLEAR;
                else if (req_valid)
                    next_state = in_range ? S_CELL : S_DONE;
            end
            S_CELL, S_CLEAR: begin
                if (pix_last_q)
                    next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            writeEn    <= 1'b0;
            pix_last_q <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            alive_q    <= 1'b0;
        end else begin
            state      <= next_state;
            writeEn    <= emit;
            pix_last_q <= emit && scan_last;
            if (emit) begin
                x      <= px_x;
                y      <= px_y;
                colour <= px_colour;
            end
            if (req_ready && req_valid) begin
                row_q   <= req_row;
                col_q   <= req_col;
                alive_q <= req_alive;
            end
        end
    end

endmodule
